cpu_prog_loader: RTL and testbench

//  Hardware harness controller for cpu_sequential; the synthesizable counterpart of the bench that drives it.
//  - Streams a program into instruction memory and zero-fills the unused words.
//  - Releases the CPU from reset and counts executed cycles.
//  - Detects halt (all-zero instruction) or a watchdog timeout.
//  - Streams data-memory contents out.

---
 rtl/cpu_prog_loader.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_prog_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_prog_loader
// Description : Harness controller for cpu_sequential. Streams a program into
//               instruction memory and zero-fills the unused words. Then it
//               releases the CPU from reset and counts the cycles it executes.
//               It stops on a halt word (all zeros) or when the watchdog
//               fires. Finally it streams the data-memory contents out.
//               Optional feature macro: LOADER_TRACE_EN adds a per-cycle
//               instruction trace port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_prog_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 32,
    parameter int XLEN       = 64,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [31:0]                   load_data,
    input  logic                          load_last,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          cpu_reset,
    input  logic [31:0]                   cpu_instr,
    output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
    input  logic [XLEN-1:0]               dmem_rdata,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [XLEN-1:0]               dump_data,
    output logic                          dump_last,
    output logic [31:0]                   cycle_count,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout
`ifdef LOADER_TRACE_EN
    ,
    output logic                          trace_valid,
    output logic [31:0]                   trace_instr
`endif
);

    localparam int c_AW = $clog2(IMEM_DEPTH);
    localparam int c_DW = $clog2(DMEM_DEPTH);

    localparam logic [c_AW-1:0] c_IMEM_LAST  = c_AW'(IMEM_DEPTH - 1);
    localparam logic [c_DW-1:0] c_DMEM_LAST  = c_DW'(DMEM_DEPTH - 1);
    localparam logic [31:0]     c_MAX_CYCLES = 32'(MAX_CYCLES);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_FILL = 3'd2;
    localparam logic [2:0] c_ST_RUN  = 3'd3;
    localparam logic [2:0] c_ST_DUMP = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

    logic [2:0]      r_state;
    logic [c_AW-1:0] r_ptr;
    logic [c_DW-1:0] r_dptr;
    logic            r_imem_we;
    logic [c_AW-1:0] r_imem_addr;
    logic [31:0]     r_imem_wdata;
    logic            r_cpu_reset;
    logic            r_dump_valid;
    logic [XLEN-1:0] r_dump_data;
    logic            r_dump_last;
    logic [31:0]     r_cycle_count;
    logic            r_timeout;
    logic            w_halt;

    assign w_halt      = (cpu_instr == 32'h0);

    assign load_ready  = (r_state == c_ST_LOAD);
    assign busy        = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign done        = (r_state == c_ST_DONE);
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign cpu_reset   = r_cpu_reset;
    assign dmem_addr   = r_dptr;
    assign dump_valid  = r_dump_valid;
    assign dump_data   = r_dump_data;
    assign dump_last   = r_dump_last;
    assign cycle_count = r_cycle_count;
    assign timeout     = r_timeout;

    // Sequencer: load, fill, run with watchdog, dump; all outputs registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_ptr         <= '0;
            r_dptr        <= '0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= 32'h0;
            r_cpu_reset   <= 1'b1;
            r_dump_valid  <= 1'b0;
            r_dump_data   <= '0;
            r_dump_last   <= 1'b0;
            r_cycle_count <= 32'h0;
            r_timeout     <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            r_imem_we <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state       <= c_ST_LOAD;
                        r_ptr         <= '0;
                        r_dptr        <= '0;
                        r_cycle_count <= 32'h0;
                        r_timeout     <= 1'b0;
                    end
                end
                c_ST_LOAD: begin
                    if (load_valid) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_ptr;
                        r_imem_wdata <= load_data;
                        r_ptr        <= r_ptr + c_AW'(1);
                        // A full program leaves nothing to zero-fill.
                        if (r_ptr == c_IMEM_LAST) begin
                            r_state     <= c_ST_RUN;
                            r_cpu_reset <= 1'b0;
                        end else if (load_last) begin
                            r_state <= c_ST_FILL;
                        end
                    end
                end
                c_ST_FILL: begin
                    // Zeros after the program double as the halt word.
                    r_imem_we    <= 1'b1;
                    r_imem_addr  <= r_ptr;
                    r_imem_wdata <= 32'h0;
                    r_ptr        <= r_ptr + c_AW'(1);
                    if (r_ptr == c_IMEM_LAST) begin
                        r_state     <= c_ST_RUN;
                        r_cpu_reset <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    // Halt is checked first so it wins over a simultaneous watchdog expiry.
                    if (w_halt) begin
                        r_state     <= c_ST_DUMP;
                        r_cpu_reset <= 1'b1;
                    end else begin
                        r_cycle_count <= r_cycle_count + 32'd1;
                        if (r_cycle_count + 32'd1 == c_MAX_CYCLES) begin
                            r_timeout   <= 1'b1;
                            r_state     <= c_ST_DUMP;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                end
                c_ST_DUMP: begin
                    // Capture the word at r_dptr, hold it until accepted, then step.
                    if (!r_dump_valid) begin
                        r_dump_data  <= dmem_rdata;
                        r_dump_valid <= 1'b1;
                        r_dump_last  <= (r_dptr == c_DMEM_LAST);
                    end else if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        if (r_dump_last) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_dptr <= r_dptr + c_DW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_cpu_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef LOADER_TRACE_EN
    logic        r_trace_valid;
    logic [31:0] r_trace_instr;

    assign trace_valid = r_trace_valid;
    assign trace_instr = r_trace_instr;

    // One trace beat per counted RUN cycle, carrying the instruction seen that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trace_valid <= 1'b0;
            r_trace_instr <= 32'h0;
        end else begin
            r_trace_valid <= (r_state == c_ST_RUN) && !w_halt;
            if ((r_state == c_ST_RUN) && !w_halt) begin
                r_trace_instr <= cpu_instr;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_prog_loader
// Description : Scoreboard bench for cpu_prog_loader. It models the
//               instruction and data memories and a trivial CPU that fetches
//               sequentially. Expected imem writes, dump words, cycle counts
//               and timeout are derived from the program image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_prog_loader;

    localparam int IMEM_DEPTH = 8;
    localparam int DMEM_DEPTH = 32;
    localparam int XLEN       = 64;
    localparam int MAX_CYCLES = 100;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            load_valid;
    logic            load_ready;
    logic [31:0]     load_data;
    logic            load_last;
    logic            imem_we;
    logic [2:0]      imem_addr;
    logic [31:0]     imem_wdata;
    logic            cpu_reset;
    logic [31:0]     cpu_instr;
    logic [4:0]      dmem_addr;
    logic [XLEN-1:0] dmem_rdata;
    logic            dump_valid;
    logic            dump_ready;
    logic [XLEN-1:0] dump_data;
    logic            dump_last;
    logic [31:0]     cycle_count;
    logic            busy;
    logic            done;
    logic            timeout;

    always #5 clk = ~clk;

    cpu_prog_loader #(
        .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH),
        .XLEN(XLEN), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_instr(cpu_instr),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last),
        .cycle_count(cycle_count), .busy(busy), .done(done), .timeout(timeout)
    );

    // Environment: memories plus a CPU that fetches imem[pc] and steps pc each cycle.
    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [2:0]      pc = 3'd0;

    assign cpu_instr  = imem[pc];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        pc <= cpu_reset ? 3'd0 : pc + 3'd1;
    end

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t             exp_wr_q[$];
    logic [XLEN-1:0] exp_dump_q[$];
    logic [31:0]     prog[$];
    int              checks = 0;
    int              errors = 0;
    int              ready_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // dump_ready pattern generator: always ready, 1,0,0,1 cycle, or random.
    initial begin
        bit pat [4];
        int pidx;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pidx = 0;
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dump_ready = 1'b1;
                1: begin dump_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every imem write and dump handshake.
    logic            prev_stall = 1'b0;
    logic [XLEN-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("dump_hold_valid", 64'(dump_valid), 64'd1);
                chk("dump_hold_data", dump_data, prev_data);
            end
            if (imem_we) begin
                chk("imem_we_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("imem_addr", 64'(imem_addr), 64'(w.addr));
                    chk("imem_wdata", 64'(imem_wdata), 64'(w.data));
                end
            end
            if (dump_valid && dump_ready) begin
                chk("dump_expected", 64'(exp_dump_q.size() != 0), 64'd1);
                if (exp_dump_q.size() != 0) begin
                    logic [XLEN-1:0] d;
                    d = exp_dump_q.pop_front();
                    chk("dump_data", dump_data, d);
                    chk("dump_last", 64'(dump_last), 64'(exp_dump_q.size() == 0));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
        end
    end

    task automatic make_prog(input int n, input bit allow_zero);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            if (allow_zero && ($urandom_range(0, 5) == 0)) prog.push_back(32'h0);
            else prog.push_back($urandom | 32'h1);
        end
    endtask

    // One complete session. abort: 0 none, 1 reset mid-RUN, 2 reset mid-DUMP.
    task automatic do_run(input int n, input int mode, input bit st_load,
                          input bit st_run, input int abort);
        logic [31:0] img [IMEM_DEPTH];
        int          first;
        logic [31:0] exp_cnt;
        bit          exp_to;
        bit          ok;
        wr_t         w;

        // Reference: image is program then zeros; CPU halts at first zero word.
        first = -1;
        for (int a = 0; a < IMEM_DEPTH; a++) begin
            img[a] = (a < n) ? prog[a] : 32'h0;
            w.addr = 3'(a);
            w.data = img[a];
            exp_wr_q.push_back(w);
            if (img[a] == 32'h0 && first < 0) first = a;
        end
        if (first < 0) begin exp_cnt = 32'(MAX_CYCLES); exp_to = 1'b1; end
        else           begin exp_cnt = 32'(first);      exp_to = 1'b0; end
        for (int k = 0; k < DMEM_DEPTH; k++) exp_dump_q.push_back(dmem[k]);
        ready_mode = mode;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done", 64'(done), 64'd0);
        chk("start_count", 64'(cycle_count), 64'd0);
        chk("start_timeout", 64'(timeout), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == n - 1);
            if (st_load && i == 1) start = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (load_ready) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            chk("load_handshake", 64'(ok), 64'd1);
            @(posedge clk); #1;
            load_valid = 1'b0;
            load_last  = 1'b0;
            start      = 1'b0;
        end

        if (st_run || abort == 1) begin
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (!cpu_reset) begin ok = 1'b1; break; end
            end
            chk("reach_run", 64'(ok), 64'd1);
            @(posedge clk); #1;
            if (st_run) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (abort == 1) repeat (5) begin @(posedge clk); #1; end
        end
        if (abort == 2) begin
            ok = 1'b0;
            for (int t = 0; t < 1000; t++) begin
                @(negedge clk);
                if (dump_valid) begin ok = 1'b1; break; end
            end
            chk("reach_dump", 64'(ok), 64'd1);
            repeat (3) @(posedge clk);
        end

        if (abort != 0) begin
            @(posedge clk); #3;
            reset_n = 1'b0;
            #1;
            chk("abort_cpu_reset", 64'(cpu_reset), 64'd1);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_dump_valid", 64'(dump_valid), 64'd0);
            chk("abort_imem_we", 64'(imem_we), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            exp_wr_q.delete();
            exp_dump_q.delete();
            @(posedge clk); #1;
            reset_n = 1'b1;
            @(posedge clk); #1;
            return;
        end

        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk("run_done", 64'(ok), 64'd1);
        chk("cycle_count", 64'(cycle_count), 64'(exp_cnt));
        chk("timeout", 64'(timeout), 64'(exp_to));
        chk("done_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
        chk("dump_q_drained", 64'(exp_dump_q.size()), 64'd0);
        exp_wr_q.delete();
        exp_dump_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        for (int k = 0; k < DMEM_DEPTH; k++) dmem[k] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_dump_valid", 64'(dump_valid), 64'd0);
        chk("rst_dump_last", 64'(dump_last), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fixed five-word program ending in the halt word.
        prog = '{32'h00000663, 32'h00400313, 32'h00800393, 32'h00400293, 32'h00000000};
        do_run(5, 0, 1'b0, 1'b0, 0);
        chk("t1_count_literal", 64'(cycle_count), 64'd4);

        // Full non-zero program: no fill, watchdog fires; start pulses ignored.
        make_prog(IMEM_DEPTH, 1'b0);
        do_run(IMEM_DEPTH, 2, 1'b1, 1'b1, 0);

        // Dump pattern k*3 with ready toggling 1,0,0,1.
        for (int k = 0; k < DMEM_DEPTH; k++) dmem[k] = 64'(k * 3);
        make_prog($urandom_range(2, 7), 1'b0);
        do_run(prog.size(), 1, 1'b1, 1'b0, 0);

        // Random programs, lengths, gaps and ready behaviour.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < DMEM_DEPTH; k++) dmem[k] = {$urandom, $urandom};
            make_prog($urandom_range(1, IMEM_DEPTH), 1'b1);
            do_run(prog.size(), $urandom_range(0, 2), 1'b0, 1'b0, 0);
        end

        // Reset mid-RUN and mid-DUMP, each followed by an identical rerun.
        make_prog(IMEM_DEPTH, 1'b0);
        do_run(IMEM_DEPTH, 1, 1'b0, 1'b0, 1);
        do_run(IMEM_DEPTH, 0, 1'b0, 1'b0, 0);
        do_run(IMEM_DEPTH, 1, 1'b0, 1'b0, 2);
        do_run(IMEM_DEPTH, 1, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
